// File: rtl/enemy_chaser.sv
// Frame-rate enemy sprite: chases the ship one step per move tick,
// reports collisions and respawns after a fixed number of frames.
module enemy_chaser #(
  parameter int SPAWN_X        = 40,
  parameter int SPAWN_Y        = 40,
  parameter int ENEMY_SIZE     = 8,
  parameter int STEP           = 1,
  parameter int MOVE_DIV       = 2,
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       enable,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] PlayerS,
  output logic [9:0] EnemyX,
  output logic [9:0] EnemyY,
  output logic [9:0] EnemyS,
  output logic       EnemyActive,
  output logic       Hit,
  output logic [7:0] HitCount
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHASE = 2'd1;
  localparam logic [1:0] DEAD  = 2'd2;

  localparam logic [9:0] SX = 10'(SPAWN_X);
  localparam logic [9:0] SY = 10'(SPAWN_Y);
  localparam logic [9:0] SZ = 10'(ENEMY_SIZE);
  localparam logic [9:0] ST = 10'(STEP);

  localparam logic [15:0] DIV_LAST  = 16'(MOVE_DIV - 1);
  localparam logic [15:0] RESP_LAST = 16'(RESPAWN_FRAMES - 1);

  logic [1:0]  state;
  logic [15:0] div_cnt;
  logic [15:0] resp_cnt;
  logic [9:0]  dx;
  logic [9:0]  dy;
  logic [9:0]  step_x;
  logic [9:0]  step_y;
  logic [10:0] reach;
  logic        overlap;
  logic        tick;

  assign EnemyS = SZ;

  // Distance to the ship, overlap test and clamped per-axis step.
  always_comb begin
    dx = (EnemyX >= PlayerX) ? EnemyX - PlayerX : PlayerX - EnemyX;
    dy = (EnemyY >= PlayerY) ? EnemyY - PlayerY : PlayerY - EnemyY;
    reach = {1'b0, SZ} + {1'b0, PlayerS};
    overlap = ({1'b0, dx} <= reach) && ({1'b0, dy} <= reach);
    step_x = (dx < ST) ? dx : ST;
    step_y = (dy < ST) ? dy : ST;
    tick = (div_cnt == DIV_LAST);
  end

  // Game state, position and hit bookkeeping.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      EnemyX      <= SX;
      EnemyY      <= SY;
      EnemyActive <= 1'b0;
      Hit         <= 1'b0;
      HitCount    <= 8'd0;
      div_cnt     <= 16'd0;
      resp_cnt    <= 16'd0;
    end else if (!enable) begin
      state       <= IDLE;
      EnemyX      <= SX;
      EnemyY      <= SY;
      EnemyActive <= 1'b0;
      Hit         <= 1'b0;
      div_cnt     <= 16'd0;
    end else begin
      Hit <= 1'b0;
      case (state)
        IDLE: begin
          state       <= CHASE;
          EnemyActive <= 1'b1;
          div_cnt     <= 16'd0;
        end
        CHASE: begin
          if (overlap) begin
            Hit         <= 1'b1;
            if (HitCount != 8'hFF)
              HitCount  <= HitCount + 8'd1;
            EnemyActive <= 1'b0;
            state       <= DEAD;
            resp_cnt    <= RESP_LAST;
            EnemyX      <= SX;
            EnemyY      <= SY;
          end else if (tick) begin
            div_cnt <= 16'd0;
            EnemyX  <= (EnemyX < PlayerX) ? EnemyX + step_x
                                          : EnemyX - step_x;
            EnemyY  <= (EnemyY < PlayerY) ? EnemyY + step_y
                                          : EnemyY - step_y;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
        end
        DEAD: begin
          if (resp_cnt == 16'd0) begin
            state       <= CHASE;
            EnemyActive <= 1'b1;
            div_cnt     <= 16'd0;
          end else begin
            resp_cnt <= resp_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_chaser.sv
// Bench for enemy_chaser: two parameterisations driven in parallel
// and checked every frame against a behavioural game model.
module tb_enemy_chaser;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       en = 1'b1;
  logic [9:0] px = 10'd320;
  logic [9:0] py = 10'd240;
  logic [9:0] ps = 10'd12;

  logic [9:0] ax, ay, as_;
  logic       aact, ahit;
  logic [7:0] ahc;
  logic [9:0] bx, by, bs;
  logic       bact, bhit;
  logic [7:0] bhc;

  int errors = 0;
  int checks = 0;

  always #5 frame_clk = ~frame_clk;

  enemy_chaser u_a (
    .Reset(Reset), .frame_clk(frame_clk), .enable(en),
    .PlayerX(px), .PlayerY(py), .PlayerS(ps),
    .EnemyX(ax), .EnemyY(ay), .EnemyS(as_),
    .EnemyActive(aact), .Hit(ahit), .HitCount(ahc)
  );

  enemy_chaser #(
    .STEP(4), .MOVE_DIV(1), .RESPAWN_FRAMES(1)
  ) u_b (
    .Reset(Reset), .frame_clk(frame_clk), .enable(en),
    .PlayerX(px), .PlayerY(py), .PlayerS(ps),
    .EnemyX(bx), .EnemyY(by), .EnemyS(bs),
    .EnemyActive(bact), .Hit(bhit), .HitCount(bhc)
  );

  // Model: mode 0 idle, 1 chasing, 2 dead.
  int step_p[2] = '{1, 4};
  int div_p[2]  = '{2, 1};
  int resp_p[2] = '{120, 1};
  int mx[2], my[2], mact[2], mhit[2], mhc[2];
  int mode[2], chase_n[2], rsp_at[2];
  int edge_n = 0;

  task automatic cmp(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic int toward(input int c, input int t, input int s);
    if (c < t) return c + (((t - c) < s) ? (t - c) : s);
    if (c > t) return c - (((c - t) < s) ? (c - t) : s);
    return c;
  endfunction

  task automatic mreset(input int k);
    mx[k] = 40; my[k] = 40; mact[k] = 0; mhit[k] = 0;
    mhc[k] = 0; mode[k] = 0; chase_n[k] = 0; rsp_at[k] = 0;
  endtask

  task automatic mstep(input int k);
    int dx, dy, r;
    if (!en) begin
      mode[k] = 0; mx[k] = 40; my[k] = 40;
      mact[k] = 0; mhit[k] = 0;
    end else if (mode[k] == 0) begin
      mode[k] = 1; mact[k] = 1; mhit[k] = 0; chase_n[k] = 0;
    end else if (mode[k] == 1) begin
      dx = (mx[k] > int'(px)) ? mx[k] - int'(px) : int'(px) - mx[k];
      dy = (my[k] > int'(py)) ? my[k] - int'(py) : int'(py) - my[k];
      r = 8 + int'(ps);
      if (dx <= r && dy <= r) begin
        mhit[k] = 1;
        mhc[k] = (mhc[k] < 255) ? mhc[k] + 1 : 255;
        mact[k] = 0; mode[k] = 2;
        mx[k] = 40; my[k] = 40;
        rsp_at[k] = edge_n + resp_p[k];
      end else begin
        mhit[k] = 0;
        chase_n[k]++;
        if (chase_n[k] % div_p[k] == 0) begin
          mx[k] = toward(mx[k], int'(px), step_p[k]);
          my[k] = toward(my[k], int'(py), step_p[k]);
        end
      end
    end else begin
      mhit[k] = 0;
      if (edge_n == rsp_at[k]) begin
        mode[k] = 1; mact[k] = 1; chase_n[k] = 0;
      end
    end
  endtask

  // Advance the model on each edge and compare both DUTs just after.
  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      mreset(0); mreset(1);
    end else begin
      edge_n++;
      mstep(0); mstep(1);
    end
    #1;
    cmp("a_x", int'(ax), mx[0]);
    cmp("a_y", int'(ay), my[0]);
    cmp("a_s", int'(as_), 8);
    cmp("a_act", int'(aact), mact[0]);
    cmp("a_hit", int'(ahit), mhit[0]);
    cmp("a_hc", int'(ahc), mhc[0]);
    cmp("b_x", int'(bx), mx[1]);
    cmp("b_y", int'(by), my[1]);
    cmp("b_s", int'(bs), 8);
    cmp("b_act", int'(bact), mact[1]);
    cmp("b_hit", int'(bhit), mhit[1]);
    cmp("b_hc", int'(bhc), mhc[1]);
  end

  task automatic tick1();
    @(posedge frame_clk);
    #2;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick1();
  endtask

  task automatic rst_on(input int x, input int y, input int s);
    Reset = 1'b1;
    en = 1'b1;
    px = 10'(x); py = 10'(y); ps = 10'(s);
    ticks(2);
  endtask

  initial begin
    int k;
    mreset(0); mreset(1);
    rst_on(320, 240, 12);
    cmp("rst_x", int'(ax), 40);
    cmp("rst_y", int'(ay), 40);
    cmp("rst_s", int'(as_), 8);
    cmp("rst_act", int'(aact), 0);
    cmp("rst_hit", int'(ahit), 0);
    cmp("rst_hc", int'(ahc), 0);
    Reset = 1'b0;
    tick1();
    cmp("en_act", int'(aact), 1);
    ticks(2);
    cmp("step1_x", int'(ax), 41);
    cmp("step1_y", int'(ay), 41);
    ticks(2);
    cmp("step2_x", int'(ax), 42);
    cmp("step2_y", int'(ay), 42);

    rst_on(40, 240, 12);
    Reset = 1'b0;
    ticks(3);
    cmp("hold_x", int'(ax), 40);
    cmp("hold_y", int'(ay), 41);

    rst_on(42, 240, 12);
    Reset = 1'b0;
    ticks(2);
    cmp("clamp_x", int'(bx), 42);
    tick1();
    cmp("clamp_hold_x", int'(bx), 42);

    rst_on(61, 40, 12);
    Reset = 1'b0;
    ticks(3);
    cmp("nohit21", int'(ahit), 0);
    cmp("nohit21_x", int'(ax), 41);
    tick1();
    cmp("hit20", int'(ahit), 1);
    cmp("hit20_hc", int'(ahc), 1);
    k = 0;
    while (k < 200 && !aact) begin
      tick1();
      k++;
    end
    cmp("dead_len", k, 120);
    cmp("respawn_x", int'(ax), 40);
    cmp("respawn_y", int'(ay), 40);

    rst_on(60, 40, 12);
    Reset = 1'b0;
    ticks(2);
    cmp("int_hit", int'(ahit), 1);
    cmp("int_hc", int'(ahc), 1);
    tick1();
    cmp("int_pulse", int'(ahit), 0);
    en = 1'b0;
    tick1();
    cmp("int_idle_act", int'(aact), 0);
    ticks(5);
    cmp("int_idle_act2", int'(aact), 0);
    cmp("int_keep_hc", int'(ahc), 1);
    en = 1'b1;
    tick1();
    cmp("int_reen_act", int'(aact), 1);
    tick1();
    cmp("int_hc2", int'(ahc), 2);
    ticks(3);
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    cmp("async_hc", int'(ahc), 0);
    cmp("async_act", int'(aact), 0);
    cmp("async_x", int'(ax), 40);
    cmp("async_bhc", int'(bhc), 0);

    rst_on(40, 40, 12);
    Reset = 1'b0;
    ticks(601);
    cmp("sat_bhc", int'(bhc), 255);
    cmp("sat_ahc", int'(ahc), 5);

    rst_on(80, 80, 10);
    Reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge frame_clk);
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 9) == 0) begin
          px = 10'($urandom_range(0, 1023));
          py = 10'($urandom_range(0, 1023));
        end else begin
          px = 10'($urandom_range(10, 100));
          py = 10'($urandom_range(10, 100));
        end
        ps = 10'($urandom_range(0, 20));
      end
      en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 499) == 0) begin
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
